// File: rtl/weapon_pkg.sv
`default_nettype none
// ============================================================================
// Package  : weapon_pkg
// Brief    : Shared attack-state enum, character class codes and default
//            frame counts for the weapon attack controller.
// Revision : 1.0 - initial release
// ============================================================================
package weapon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WINDUP   = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } attack_state_t;

  localparam logic CLASS_MELEE  = 1'b0;
  localparam logic CLASS_ARCHER = 1'b1;

  localparam int DEFAULT_WINDUP_FRAMES   = 2;
  localparam int DEFAULT_ACTIVE_FRAMES   = 4;
  localparam int DEFAULT_COOLDOWN_FRAMES = 8;

endpackage
`default_nettype wire

// File: rtl/weapon_attack_ctl_if.sv
`default_nettype none
// ============================================================================
// Interface : weapon_attack_ctl_if
// Brief     : Game-side inputs and sprite/projectile outputs of the weapon
//             attack controller.
// Revision  : 1.0 - initial release
// ============================================================================
interface weapon_attack_ctl_if;

  logic       frame_tick;
  logic       mouse_clicked;
  logic       char_class;
  logic       flip_hor;
  logic       proj_busy;
  logic       draw_weapon;
  logic       melee_hit;
  logic       proj_spawn;
  logic       proj_dir;
  logic       busy;
  logic [1:0] attack_state;

  modport master (
    output frame_tick, mouse_clicked, char_class, flip_hor, proj_busy,
    input  draw_weapon, melee_hit, proj_spawn, proj_dir, busy, attack_state
  );

  modport slave (
    input  frame_tick, mouse_clicked, char_class, flip_hor, proj_busy,
    output draw_weapon, melee_hit, proj_spawn, proj_dir, busy, attack_state
  );

endinterface
`default_nettype wire

// File: rtl/frame_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_down_counter
// Brief    : 8-bit loadable frame down-counter; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module frame_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] r_count;

  // Load wins over tick so a tick in the load cycle is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_value;
    end else if (tick && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/weapon_attack_ctl.sv
`default_nettype none
// ============================================================================
// Module   : weapon_attack_ctl
// Brief    : IDLE/WINDUP/ACTIVE/COOLDOWN attack sequencer timed in frames.
//            Define WEAPON_AUTO_FIRE_EN for level-triggered auto fire.
// Revision : 1.0 - initial release
// ============================================================================
module weapon_attack_ctl
  import weapon_pkg::*;
#(
  parameter int WINDUP_FRAMES   = DEFAULT_WINDUP_FRAMES,
  parameter int ACTIVE_FRAMES   = DEFAULT_ACTIVE_FRAMES,
  parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
  input  logic                clk,
  input  logic                rst,
  weapon_attack_ctl_if.slave  bus
);

  localparam logic [7:0] c_windup   = 8'(WINDUP_FRAMES);
  localparam logic [7:0] c_active   = 8'(ACTIVE_FRAMES);
  localparam logic [7:0] c_cooldown = 8'(COOLDOWN_FRAMES);

  attack_state_t r_state;
  logic          r_entry;
  logic          r_class;
  logic          r_dir;
  logic          r_draw;
  logic          r_hit;
  logic          r_spawn;
  logic          r_busy;
  logic          w_trigger;
  logic          w_zero;
  logic          w_done;
  logic [7:0]    w_load_value;

`ifdef WEAPON_AUTO_FIRE_EN
  assign w_trigger = bus.mouse_clicked;
`else
  logic r_mouse_prev;
  logic r_armed;

  // r_armed blocks a button held across reset until it is released once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mouse_prev <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_mouse_prev <= bus.mouse_clicked;
      if (!bus.mouse_clicked) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_trigger = bus.mouse_clicked && !r_mouse_prev && r_armed;
`endif

  always_comb begin
    w_load_value = 8'd0;
    case (r_state)
      WINDUP:   w_load_value = c_windup;
      ACTIVE:   w_load_value = c_active;
      COOLDOWN: w_load_value = c_cooldown;
      default:  w_load_value = 8'd0;
    endcase
  end

  frame_down_counter u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (r_entry),
    .load_value (w_load_value),
    .tick       (bus.frame_tick),
    .zero       (w_zero)
  );

  // The counter is reloaded during the entry cycle, so its zero flag is stale there.
  assign w_done = w_zero && !r_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_entry <= 1'b0;
      r_class <= 1'b0;
      r_dir   <= 1'b0;
      r_draw  <= 1'b0;
      r_hit   <= 1'b0;
      r_spawn <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_entry <= 1'b0;
      r_spawn <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger && !((bus.char_class == CLASS_ARCHER) && bus.proj_busy)) begin
            r_state <= WINDUP;
            r_entry <= 1'b1;
            r_class <= bus.char_class;
            r_dir   <= bus.flip_hor;
            r_draw  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        WINDUP: begin
          if (w_done) begin
            r_state <= ACTIVE;
            r_entry <= 1'b1;
            r_hit   <= (r_class == CLASS_MELEE);
            r_spawn <= (r_class == CLASS_ARCHER);
          end
        end
        ACTIVE: begin
          if (w_done) begin
            r_state <= COOLDOWN;
            r_entry <= 1'b1;
            r_draw  <= 1'b0;
            r_hit   <= 1'b0;
          end
        end
        COOLDOWN: begin
          if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.draw_weapon  = r_draw;
  assign bus.melee_hit    = r_hit;
  assign bus.proj_spawn   = r_spawn;
  assign bus.proj_dir     = r_dir;
  assign bus.busy         = r_busy;
  assign bus.attack_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_weapon_attack_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weapon_attack_ctl
// Brief    : Scoreboard bench: per-cycle expectations from a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weapon_attack_ctl;
  import weapon_pkg::*;

  localparam int NCYC = 1400;
  localparam int WF   = 2;
  localparam int AF   = 4;
  localparam int CF   = 8;

  typedef struct packed {
    logic [1:0] st;
    logic       draw;
    logic       hit;
    logic       spawn;
    logic       dir;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weapon_attack_ctl_if bus();

  weapon_attack_ctl #(
    .WINDUP_FRAMES   (WF),
    .ACTIVE_FRAMES   (AF),
    .COOLDOWN_FRAMES (CF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit   s_rst [NCYC];
  bit   s_m   [NCYC];
  bit   s_c   [NCYC];
  bit   s_f   [NCYC];
  bit   s_p   [NCYC];
  bit   s_t   [NCYC];
  obs_t exp_arr [NCYC];
  obs_t sb_q [$];
  int   n_stim = 0;
  int   mon_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic put(input bit r, input bit m, input bit c, input bit f,
                     input bit p, input bit t);
    if (n_stim < NCYC) begin
      s_rst[n_stim] = r;
      s_m[n_stim]   = m;
      s_c[n_stim]   = c;
      s_f[n_stim]   = f;
      s_p[n_stim]   = p;
      s_t[n_stim]   = t;
      n_stim++;
    end
  endtask

  function automatic int frames_of(input int ph);
    case (ph)
      1:       return WF;
      2:       return AF;
      default: return CF;
    endcase
  endfunction

  // Timeline model: a phase starting at cycle s ends once its N-th tick after s
  // has been seen at cycle t; the next phase then starts at t+2.
  task automatic build_model();
    int ph, start, cnt, tdone;
    bit lcls, ldir, trig, prev_m, prev_r;
    obs_t e;
    ph = 0; start = 0; cnt = 0; tdone = -10; lcls = 1'b0; ldir = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      if (s_rst[k]) begin
        ph = 0; lcls = 1'b0; ldir = 1'b0; tdone = -10; cnt = 0;
        exp_arr[k] = '0;
        continue;
      end
      e.st    = 2'(ph);
      e.draw  = (ph == 1) || (ph == 2);
      e.hit   = (ph == 2) && !lcls;
      e.spawn = (ph == 2) && (k == start) && lcls;
      e.dir   = ldir;
      e.busy  = (ph != 0);
      exp_arr[k] = e;
      if (ph == 0) begin
        prev_m = (k > 0) ? s_m[k-1] : 1'b0;
        prev_r = (k > 0) ? s_rst[k-1] : 1'b1;
`ifdef WEAPON_AUTO_FIRE_EN
        trig = s_m[k];
`else
        trig = s_m[k] && !prev_m && !prev_r;
`endif
        if (trig && !(s_c[k] && s_p[k])) begin
          ph = 1; start = k + 1; cnt = 0; tdone = -10;
          lcls = s_c[k]; ldir = s_f[k];
        end
      end else begin
        if (tdone >= 0 && k == tdone + 1) begin
          ph = (ph + 1) % 4; start = k + 1; cnt = 0; tdone = -10;
        end else if (k > start && s_t[k] && cnt < frames_of(ph)) begin
          cnt++;
          if (cnt == frames_of(ph)) tdone = k;
        end
      end
    end
  endtask

  task automatic build_stimulus();
    bit m, c, f, p;
    int rhold;
    repeat (3) put(1, 0, 0, 0, 0, 0);
    repeat (4) put(0, 0, 0, 0, 0, 0);
    // Melee, tick on WINDUP entry, second click lands in COOLDOWN.
    for (int i = 0; i < 90; i++)
      put(0, (i >= 1 && i < 4) || (i >= 45 && i < 48), CLASS_MELEE, 0, 0, (i % 4) == 2);
    // Archer facing left; class and facing change mid-attack.
    for (int i = 0; i < 60; i++)
      put(0, (i >= 1 && i < 3), (i < 10) ? CLASS_ARCHER : CLASS_MELEE, (i < 12), 0, (i % 3) == 0);
    // Archer blocked by a projectile in flight.
    for (int i = 0; i < 20; i++)
      put(0, (i >= 2 && i < 5), CLASS_ARCHER, 1, 1, (i % 3) == 0);
    // Archer where proj_busy rises during WINDUP.
    for (int i = 0; i < 60; i++)
      put(0, (i >= 1 && i < 3), CLASS_ARCHER, 0, (i >= 3), (i % 3) == 0);
    // Button held well past COOLDOWN.
    for (int i = 0; i < 90; i++)
      put(0, (i >= 1 && i < 80), CLASS_MELEE, 0, 0, (i % 3) == 1);
    repeat (4) put(0, 0, 0, 0, 0, 0);
    m = 0; c = 0; f = 0; p = 0; rhold = 0;
    while (n_stim < NCYC) begin
      if (rhold == 0 && $urandom_range(0, 249) == 0) rhold = $urandom_range(1, 2);
      if ($urandom_range(0, 5) == 0)  m = !m;
      if ($urandom_range(0, 19) == 0) c = !c;
      if ($urandom_range(0, 3) == 0)  f = !f;
      if ($urandom_range(0, 7) == 0)  p = !p;
      put(rhold != 0, m, c, f, p, $urandom_range(0, 2) == 0);
      if (rhold != 0) rhold--;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = sb_q.pop_front();
      a = {bus.attack_state, bus.draw_weapon, bus.melee_hit, bus.proj_spawn,
           bus.proj_dir, bus.busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb cycle %0d: got st=%0d draw=%b hit=%b spawn=%b dir=%b busy=%b, exp st=%0d draw=%b hit=%b spawn=%b dir=%b busy=%b",
                 mon_cyc, a.st, a.draw, a.hit, a.spawn, a.dir, a.busy,
                 e.st, e.draw, e.hit, e.spawn, e.dir, e.busy);
      end
      mon_cyc++;
    end
  end

  initial begin
    bit seen;
    bit any_busy;
    rst = 1'b1;
    bus.frame_tick    = 1'b0;
    bus.mouse_clicked = 1'b0;
    bus.char_class    = 1'b0;
    bus.flip_hor      = 1'b0;
    bus.proj_busy     = 1'b0;
    build_stimulus();
    build_model();

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      rst               = s_rst[k];
      bus.mouse_clicked = s_m[k];
      bus.char_class    = s_c[k];
      bus.flip_hor      = s_f[k];
      bus.proj_busy     = s_p[k];
      bus.frame_tick    = s_t[k];
      sb_q.push_back(exp_arr[k]);
    end
    @(negedge clk);
    #1;

    // Asynchronous reset in the middle of ACTIVE with the button held.
    rst = 1'b1; bus.mouse_clicked = 1'b0; bus.frame_tick = 1'b0;
    bus.char_class = CLASS_MELEE; bus.flip_hor = 1'b1; bus.proj_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.mouse_clicked = 1'b1; bus.frame_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.attack_state == 2'd2 && bus.melee_hit && bus.proj_dir) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_active: melee ACTIVE with proj_dir=1 not seen within 50 cycles, got st=%0d",
               bus.attack_state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.attack_state, bus.draw_weapon, bus.melee_hit, bus.proj_spawn,
         bus.proj_dir, bus.busy} !== 7'd0) begin
      errors++;
      $display("FAIL async_rst: got st=%0d draw=%b hit=%b spawn=%b dir=%b busy=%b, exp all 0",
               bus.attack_state, bus.draw_weapon, bus.melee_hit, bus.proj_spawn,
               bus.proj_dir, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) any_busy = 1'b1;
    end
    checks++;
`ifdef WEAPON_AUTO_FIRE_EN
    if (!any_busy) begin
      errors++;
      $display("FAIL held_after_rst: got busy never set, exp auto-fire attack");
    end
`else
    if (any_busy) begin
      errors++;
      $display("FAIL held_after_rst: got busy=1, exp no attack from held button");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
